// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between the truth-table checker and its gate under test.
// Carries the sweep handshake, the gate stimulus/response and the result fields.
interface gate_truth_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    logic              start;
    logic [N_IN-1:0]   stim;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic              fail_valid;
    logic [N_IN-1:0]   first_fail;

    // Controller / gate side: starts sweeps, closes the loop through the gate.
    modport master (
        output start,
        output dut_out,
        input  stim,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_valid,
        input  first_fail
    );

    // Checker side.
    modport slave (
        input  start,
        input  dut_out,
        output stim,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_valid,
        output first_fail
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps all input vectors of a combinational gate and checks it against EXP_TT.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_truth_checker #(
    parameter int                    N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]  EXP_TT = 4'b1000,
    parameter int                    SETTLE = 2,
    parameter int                    ERR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gate_truth_checker_if.slave     bus
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    stim_q, stim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fv_q, fv_d;
    logic [N_IN-1:0]    ff_q, ff_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               mismatch;
    logic               last_vec;

    assign mismatch = (bus.dut_out != EXP_TT[stim_q]);
    assign last_vec = (stim_q == {N_IN{1'b1}});

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WAIT;
                    stim_d  = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        ff_d = stim_q;
                    end
                end
                // pass is registered alongside done so both appear together.
                if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    state_d = S_WAIT;
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign bus.stim       = stim_q;
    assign bus.busy       = (state_q == S_WAIT) || (state_q == S_CHECK);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: default build and ERR_W=1 instance.
// Expected values are hand-derived for both stop-on-fail settings.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_r = 1'b0;
    logic sel = 1'b0;
    int   mode = 0;
    int   n_chk = 0;
    int   n_ok = 0;

    always #5 clk = ~clk;

    gate_truth_checker_if #(.N_IN(2), .ERR_W(8)) ifa ();
    gate_truth_checker_if #(.N_IN(2), .ERR_W(1)) ifb ();

    gate_truth_checker #(.N_IN(2), .EXP_TT(4'b1000), .SETTLE(2), .ERR_W(8)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    gate_truth_checker #(.N_IN(2), .EXP_TT(4'b1000), .SETTLE(2), .ERR_W(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    function automatic logic gate(input int m, input logic [1:0] s);
        case (m)
            0:       return s[1] & s[0];
            1:       return 1'b0;
            2:       return 1'b1;
            default: return s[1] | s[0];
        endcase
    endfunction

    assign ifa.start   = sel ? 1'b0 : start_r;
    assign ifb.start   = sel ? start_r : 1'b0;
    assign ifa.dut_out = gate(mode, ifa.stim);
    assign ifb.dut_out = gate(mode, ifb.stim);

    logic [1:0] stim_s, ff_s;
    logic [7:0] err_s;
    logic       busy_s, done_s, pass_s, fv_s;

    assign stim_s = sel ? ifb.stim : ifa.stim;
    assign ff_s   = sel ? ifb.first_fail : ifa.first_fail;
    assign err_s  = sel ? 8'(ifb.err_cnt) : ifa.err_cnt;
    assign busy_s = sel ? ifb.busy : ifa.busy;
    assign done_s = sel ? ifb.done : ifa.done;
    assign pass_s = sel ? ifb.pass : ifa.pass;
    assign fv_s   = sel ? ifb.fail_valid : ifa.fail_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic sweep(input bit s, input int m, input int retrig,
                         input bit chk_stim, output int lat);
        sel  = s;
        mode = m;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        lat = 0;
        chk("accept_busy", 32'(busy_s), 32'd1);
        while (!done_s && lat < 40) begin
            if (chk_stim) chk("stim_step", 32'(stim_s), 32'(lat / 3));
            start_r = (lat == retrig);
            @(posedge clk);
            #1;
            lat++;
        end
        start_r = 1'b0;
        chk("done_seen", 32'(done_s), 32'd1);
    endtask

    task automatic after_done(input logic exp_pass);
        chk("busy_at_done", 32'(busy_s), 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done_s), 32'd0);
        chk("pass_hold", 32'(pass_s), 32'(exp_pass));
    endtask

    initial begin
        int lat;
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stim", 32'(ifa.stim), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_pass", 32'(ifa.pass), 32'd0);
        chk("rst_err", 32'(ifa.err_cnt), 32'd0);
        chk("rst_fv", 32'(ifa.fail_valid), 32'd0);
        chk("rst_ff", 32'(ifa.first_fail), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good AND gate.
        sweep(1'b0, 0, -1, 1'b1, lat);
        chk("and_lat", 32'(lat), 32'd12);
        chk("and_pass", 32'(pass_s), 32'd1);
        chk("and_err", 32'(err_s), 32'd0);
        chk("and_fv", 32'(fv_s), 32'd0);
        chk("and_stim_end", 32'(stim_s), 32'd3);
        after_done(1'b1);

        // Output stuck at 0: only vector 3 fails.
        sweep(1'b0, 1, -1, 1'b0, lat);
        chk("t0_lat", 32'(lat), 32'd12);
        chk("t0_err", 32'(err_s), 32'd1);
        chk("t0_fv", 32'(fv_s), 32'd1);
        chk("t0_ff", 32'(ff_s), 32'd3);
        chk("t0_pass", 32'(pass_s), 32'd0);
        after_done(1'b0);

        // Output stuck at 1, extra start mid-sweep.
        sweep(1'b0, 2, 5, 1'b0, lat);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        chk("t1_lat", 32'(lat), 32'd3);
        chk("t1_err", 32'(err_s), 32'd1);
        chk("t1_stim", 32'(stim_s), 32'd0);
`else
        chk("t1_lat", 32'(lat), 32'd12);
        chk("t1_err", 32'(err_s), 32'd3);
        chk("t1_stim", 32'(stim_s), 32'd3);
`endif
        chk("t1_fv", 32'(fv_s), 32'd1);
        chk("t1_ff", 32'(ff_s), 32'd0);
        chk("t1_pass", 32'(pass_s), 32'd0);
        after_done(1'b0);

        // ERR_W=1 instance with an OR gate.
        sweep(1'b1, 3, -1, 1'b0, lat);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        chk("or_lat", 32'(lat), 32'd6);
        chk("or_stim", 32'(stim_s), 32'd1);
`else
        chk("or_lat", 32'(lat), 32'd12);
        chk("or_stim", 32'(stim_s), 32'd3);
`endif
        chk("or_err_sat", 32'(err_s), 32'd1);
        chk("or_fv", 32'(fv_s), 32'd1);
        chk("or_ff", 32'(ff_s), 32'd1);
        chk("or_pass", 32'(pass_s), 32'd0);
        after_done(1'b0);

        // Reset mid-sweep while stim=2.
        sel  = 1'b0;
        mode = 1;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("mid_stim", 32'(stim_s), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_stim", 32'(stim_s), 32'd0);
        chk("mr_busy", 32'(busy_s), 32'd0);
        chk("mr_done", 32'(done_s), 32'd0);
        chk("mr_pass", 32'(pass_s), 32'd0);
        chk("mr_err", 32'(err_s), 32'd0);
        chk("mr_fv", 32'(fv_s), 32'd0);
        chk("mr_ff", 32'(ff_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_s || busy_s) seen++;
        end
        chk("mr_quiet", 32'(seen), 32'd0);
        sweep(1'b0, 0, -1, 1'b1, lat);
        chk("mr_lat", 32'(lat), 32'd12);
        chk("mr_pass_ok", 32'(pass_s), 32'd1);
        chk("mr_err_ok", 32'(err_s), 32'd0);
        after_done(1'b1);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
